// File: rtl/ex_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the EX-stage iterative multiply/divide unit and for
// the controller decode that drives it.
//   - muldiv_op_e    : operation codes carried on the op field
//   - muldiv_state_e : sequencing states of the unit
//   - ITER/CNT_W     : iteration count and matching counter width
//   - isMulOp/isDivOp/isSignedOp : opcode classification helpers
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

    // Operations that run through the shift-add multiplier
    function automatic logic isMulOp(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Operations that run through the restoring divider
    function automatic logic isDivOp(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Operations whose operands are two's-complement; MADD/MSUB accumulate
    // a signed product
    function automatic logic isSignedOp(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_if
// Request/response bundle between the ID/EX controller and the mul/div unit.
//   master (controller): drives start, op, a, b, flush;
//                        observes busy, done, divByZero, hi, lo
//   slave  (unit)      : the mirror image
// ---------------------------------------------------------------------------
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit_fixup.sv
// ---------------------------------------------------------------------------
// muldiv_fixup
// Combinational result stage of the mul/div unit. Turns the unsigned
// magnitude result left by the iterative core into the value to be written
// to HI/LO: applies signs, folds in the MADD/MSUB accumulate, and handles
// the divide-by-zero result.
//   op_i        : latched operation code
//   acc_i       : core accumulator ({rem, quot} for divide, product for mul)
//   opA_i/opB_i : latched operand magnitudes
//   neg_i       : result (product / quotient) must be negated
//   aNeg_i      : dividend was negative (remainder sign)
//   hi_i/lo_i   : current HI/LO (accumulate source)
//   hi_o/lo_o   : values to commit
//   divByZero_o : divide with a zero divisor
// ---------------------------------------------------------------------------
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opA_i,
    input  logic [WIDTH-1:0]   opB_i,
    input  logic               neg_i,
    input  logic               aNeg_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [WIDTH-1:0]   lo_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               divByZero_o
);

    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] hiLo;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // The quotient lands in the low half of the accumulator and the
    // remainder in the high half. Negating magnitudes gives truncation
    // toward zero and a remainder carrying the dividend's sign. A zero
    // divisor bypasses sign fixup and returns the original dividend in HI.
    always_comb begin
        product     = neg_i ? -acc_i : acc_i;
        hiLo        = {hi_i, lo_i};
        quot        = acc_i[WIDTH-1:0];
        rem         = acc_i[2*WIDTH-1:WIDTH];
        result      = hiLo;
        divByZero_o = 1'b0;
        case (op_i)
            OP_MULT, OP_MULTU: result = product;
            OP_MADD:           result = hiLo + product;
            OP_MSUB:           result = hiLo - product;
            OP_DIV, OP_DIVU: begin
                if (opB_i == '0) begin
                    result      = {(aNeg_i ? -opA_i : opA_i), {WIDTH{1'b1}}};
                    divByZero_o = 1'b1;
                end else begin
                    result = {(aNeg_i ? -rem : rem), (neg_i ? -quot : quot)};
                end
            end
            default: result = hiLo;
        endcase
        hi_o = result[2*WIDTH-1:WIDTH];
        lo_o = result[WIDTH-1:0];
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO registers, fed
// from the ID/EX register. Multiplies are 32-step shift-add, divides are
// 32-step restoring; a final FIX cycle applies signs and commits HI/LO.
// busy stalls the front of the pipe while an operation is in flight.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ex_muldiv_unit_if.slave (start/op/a/b/flush in,
//         busy/done/divByZero/hi/lo out)
// ---------------------------------------------------------------------------
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               aNeg_q, aNeg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               launch, loadHi, loadLo, stepMul, stepDiv, commit, busy;
    logic               sgnOp;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divRem;
    logic [WIDTH-1:0]   fixHi, fixLo;
    logic               fixDbz;

    // Signed operations iterate on magnitudes; the sign is restored in FIX
    assign sgnOp = isSignedOp(bus.op);
    assign absA  = (sgnOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign absB  = (sgnOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add step: the low half starts as the multiplier and is consumed
    // one bit per cycle while the partial product grows into the high half
    assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opA_q} : {(WIDTH+1){1'b0}});

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. When it fits the difference is
    // below the divisor, so a WIDTH-bit subtract is exact.
    assign divShift = acc_q[2*WIDTH-1:WIDTH-1];
    assign divFits  = divShift >= {1'b0, opB_q};
    assign divRem   = divFits ? (divShift[WIDTH-1:0] - opB_q) : divShift[WIDTH-1:0];

    muldiv_fixup #(.WIDTH(WIDTH)) u_fixup (
        .op_i        (op_q),
        .acc_i       (acc_q),
        .opA_i       (opA_q),
        .opB_i       (opB_q),
        .neg_i       (neg_q),
        .aNeg_i      (aNeg_q),
        .hi_i        (hi_q),
        .lo_i        (lo_q),
        .hi_o        (fixHi),
        .lo_o        (fixLo),
        .divByZero_o (fixDbz)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush returns to IDLE from anywhere and also blocks a
    // launch from IDLE; the iteration states leave after the last count
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (isMulOp(bus.op)) begin
                        state_d = ST_MUL;
                    end else if (isDivOp(bus.op)) begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        busy    = (state_q != ST_IDLE);
        launch  = 1'b0;
        loadHi  = 1'b0;
        loadLo  = 1'b0;
        stepMul = 1'b0;
        stepDiv = 1'b0;
        commit  = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                ST_IDLE: begin
                    launch = bus.start && (isMulOp(bus.op) || isDivOp(bus.op));
                    loadHi = bus.start && (bus.op == OP_MTHI);
                    loadLo = bus.start && (bus.op == OP_MTLO);
                end
                ST_MUL:  stepMul = 1'b1;
                ST_DIV:  stepDiv = 1'b1;
                ST_FIX:  commit  = 1'b1;
                default: commit  = 1'b0;
            endcase
        end
    end

    // Datapath next values: latch operands at launch, iterate, then commit
    // the fixed-up result. done/divByZero are single-cycle pulses following
    // the commit edge.
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        opA_d  = opA_q;
        opB_d  = opB_q;
        acc_d  = acc_q;
        neg_d  = neg_q;
        aNeg_d = aNeg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = commit;
        dbz_d  = commit && fixDbz;
        if (launch) begin
            cnt_d  = '0;
            op_d   = bus.op;
            opA_d  = absA;
            opB_d  = absB;
            neg_d  = sgnOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            aNeg_d = sgnOp && bus.a[WIDTH-1];
            acc_d  = isMulOp(bus.op) ? {{WIDTH{1'b0}}, absB} : {{WIDTH{1'b0}}, absA};
        end
        if (stepMul) begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (stepDiv) begin
            acc_d = {divRem, acc_q[WIDTH-2:0], divFits};
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (commit) begin
            hi_d = fixHi;
            lo_d = fixLo;
        end
        if (loadHi) begin
            hi_d = bus.a;
        end
        if (loadLo) begin
            lo_d = bus.a;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= '0;
            opA_q  <= '0;
            opB_q  <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            aNeg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            opA_q  <= opA_d;
            opB_q  <= opB_d;
            acc_q  <= acc_d;
            neg_q  <= neg_d;
            aNeg_q <= aNeg_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.divByZero = dbz_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit: directed cases followed by random
// operations, each compared against a plain-arithmetic HI/LO model.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ex_muldiv_unit_if #(.WIDTH(32)) bus ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    int          compareCount = 0;
    int          failCount    = 0;
    logic [31:0] refHi;
    logic [31:0] refLo;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    // Reference model: HI/LO architectural effect of one operation, using
    // native 64-bit and signed integer arithmetic
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic expDbz);
        logic [63:0] hiLo;
        logic [63:0] sProd;
        int          sa;
        int          sb;
        expDbz = 1'b0;
        hiLo   = {refHi, refLo};
        sa     = a;
        sb     = b;
        sProd  = 64'(longint'(sa) * longint'(sb));
        case (op)
            OP_MULT:  hiLo = sProd;
            OP_MULTU: hiLo = {32'h0, a} * {32'h0, b};
            OP_MADD:  hiLo = hiLo + sProd;
            OP_MSUB:  hiLo = hiLo - sProd;
            OP_DIV: begin
                if (b == 32'h0) begin
                    hiLo   = {a, 32'hFFFF_FFFF};
                    expDbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hiLo = {32'h0, 32'h8000_0000};
                end else begin
                    hiLo = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            OP_DIVU: begin
                if (b == 32'h0) begin
                    hiLo   = {a, 32'hFFFF_FFFF};
                    expDbz = 1'b1;
                end else begin
                    hiLo = {a % b, a / b};
                end
            end
            OP_MTHI: hiLo[63:32] = a;
            OP_MTLO: hiLo[31:0]  = a;
            default: hiLo = {refHi, refLo};
        endcase
        {refHi, refLo} = hiLo;
    endtask

    // Issue one operation and follow it to completion. Optionally throws a
    // competing start in while busy, which must have no effect.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit injectStart);
        logic        expDbz;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        logic [31:0] midHi;
        logic [31:0] midLo;
        int          cycles;
        bit          sawDone;
        oldHi = refHi;
        oldLo = refLo;
        modelOp(op, a, b, expDbz);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (op == OP_MTHI || op == OP_MTLO) begin
            checkOutput("moveBusy", 64'(bus.busy), 64'(0));
            checkOutput("moveDone", 64'(bus.done), 64'(0));
            checkOutput("moveHiLo", {bus.hi, bus.lo}, {refHi, refLo});
            return;
        end
        cycles  = 0;
        sawDone = 1'b0;
        midHi   = 32'h0;
        midLo   = 32'h0;
        while (bus.busy && cycles < 100) begin
            if (bus.done) sawDone = 1'b1;
            if (cycles == 10) begin
                midHi = bus.hi;
                midLo = bus.lo;
            end
            bus.start = injectStart && (cycles == 5);
            if (bus.start) begin
                bus.op = OP_MULTU;
                bus.a  = $urandom;
                bus.b  = $urandom;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        checkOutput("busyCycles", 64'(cycles), 64'(33));
        checkOutput("doneWhileBusy", 64'(sawDone), 64'(0));
        checkOutput("readDuringBusy", {midHi, midLo}, {oldHi, oldLo});
        checkOutput("done", 64'(bus.done), 64'(1));
        checkOutput("divByZero", 64'(bus.divByZero), 64'(expDbz));
        checkOutput("hiLo", {bus.hi, bus.lo}, {refHi, refLo});
        @(negedge clk);
        checkOutput("donePulse", 64'(bus.done), 64'(0));
        checkOutput("dbzPulse", 64'(bus.divByZero), 64'(0));
    endtask

    // Random operands biased toward the interesting corner values
    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Directed sequence, then random operations, then the summary
    initial begin
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        bit          sawDone;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        bus.flush = 1'b0;
        refHi     = 32'h0;
        refLo     = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetBusy", 64'(bus.busy), 64'(0));
        checkOutput("resetDone", 64'(bus.done), 64'(0));
        checkOutput("resetDbz", 64'(bus.divByZero), 64'(0));
        checkOutput("resetHiLo", {bus.hi, bus.lo}, 64'h0);

        // Unsigned max squared, with a competing start during busy
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput("multuConst", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

        // Signed multiply and divide with negative operands
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        checkOutput("multConst", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput("divConst", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // Divide by zero and signed overflow
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b0);
        checkOutput("dbzConst", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("ovfConst", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Moves then accumulate / subtract-accumulate
        applyStimulus(OP_MTHI, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'd5, 32'd0, 1'b0);
        applyStimulus(OP_MADD, 32'd2, 32'd3, 1'b0);
        checkOutput("maddConst", {bus.hi, bus.lo}, 64'h0000_0000_0000_000B);
        applyStimulus(OP_MSUB, 32'd4, 32'd4, 1'b0);
        checkOutput("msubConst", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFB);

        // Flush on the 10th busy cycle of a divide
        oldHi = refHi;
        oldLo = refLo;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("busyBeforeFlush", 64'(bus.busy), 64'(1));
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flushBusy", 64'(bus.busy), 64'(0));
        checkOutput("flushDone", 64'(bus.done), 64'(0));
        checkOutput("flushHiLo", {bus.hi, bus.lo}, {oldHi, oldLo});
        @(negedge clk);
        checkOutput("flushLateDone", 64'(bus.done), 64'(0));

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("busyBeforeReset", 64'(bus.busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("midResetBusy", 64'(bus.busy), 64'(0));
        checkOutput("midResetDone", 64'(bus.done), 64'(0));
        checkOutput("midResetHiLo", {bus.hi, bus.lo}, 64'h0);
        refHi = 32'h0;
        refLo = 32'h0;
        @(negedge clk);
        rst     = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) sawDone = 1'b1;
        end
        checkOutput("postResetQuiet", 64'(sawDone), 64'(0));

        // Flush together with a move or a multiply start in IDLE
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.a     = 32'h0000_1234;
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("flushMoveLo", 64'(bus.lo), 64'(refLo));
        bus.op = OP_MULT;
        @(negedge clk);
        checkOutput("flushStartBusy", 64'(bus.busy), 64'(0));
        bus.start = 1'b0;
        bus.flush = 1'b0;

        // Random operations against the model
        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'($urandom_range(1, 8)), randOperand(), randOperand(),
                          ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
